alu_op_sequencer: RTL

- Command-side driver for the 16-bit ALU datapath: accepts ALU commands over a valid/ready handshake and drives the `Control` select and the operand buses.
- Waits a fixed settle time for the combinational ALU/output-mux path, captures the selected result (`nBitOut`), and returns it with flags over a second valid/ready handshake.
- Holds an accumulator so that chained operations can reuse the previous result.

---
 rtl/alu_op_sequencer.sv | 66 ++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready command front end that drives the 16-bit ALU, waits for it to settle, and returns the captured result with flags
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [1:0]       Cmd_Op,
  input  logic [WIDTH-1:0] Cmd_A,
  input  logic [WIDTH-1:0] Cmd_B,
  input  logic             Cmd_UseAcc,
  input  logic             Acc_Clr,
  output logic [1:0]       Control,
  output logic [WIDTH-1:0] Op_A,
  output logic [WIDTH-1:0] Op_B,
  input  logic [WIDTH-1:0] Alu_Result,
  output logic             Res_Valid,
  input  logic             Res_Ready,
  output logic [WIDTH-1:0] Res_Data,
  output logic             Res_Zero,
  output logic             Res_Neg,
  output logic [WIDTH-1:0] Acc
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  always_ff @(posedge Clk)
    if (Rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    Cmd_Ready = state == IDLE;
    Res_Valid = state == RESP;
    state_n = (state == IDLE && Cmd_Valid) ? ISSUE :
              (state == ISSUE && cnt == 4'd0) ? RESP :
              (state == RESP && Res_Ready) ? IDLE : state;
  end
  always_ff @(posedge Clk)
    if (Rst) begin
      Control <= 2'b00;
      Op_A <= '0;
      Op_B <= '0;
      Res_Data <= '0;
      Res_Zero <= 1'b0;
      Res_Neg <= 1'b0;
      Acc <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (Acc_Clr) Acc <= '0;
      if (Cmd_Valid) begin
        Control <= Cmd_Op;
        // a clear on the accepting edge also zeroes the chained operand
        Op_A <= Cmd_UseAcc ? (Acc_Clr ? '0 : Acc) : Cmd_A;
        Op_B <= Cmd_B;
        cnt <= 4'(SETTLE_CYCLES - 1);
      end
    end else if (state == ISSUE) begin
      if (cnt == 4'd0) begin
        Res_Data <= Alu_Result;
        Acc <= Alu_Result;
        Res_Zero <= Alu_Result == '0;
        Res_Neg <= Alu_Result[WIDTH-1];
      end else cnt <= cnt - 4'd1;
    end
endmodule
